// File: rtl/axil_register_wr.sv
// axil_register_wr: AXI4-lite write-path register slice; AW, W and B each bypassed, single- or skid-buffered.
// One generic slice is instantiated per channel; B runs in the reverse direction (m side feeds s side).

module axil_register_wr_slice #(
    parameter int WIDTH    = 32,
    parameter int REG_TYPE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    if (REG_TYPE >= 2) begin : g_skid
        logic             ready_reg, out_valid_reg, temp_valid_reg;
        logic [WIDTH-1:0] out_reg, temp_reg;
        logic             ready_early, to_out, to_temp, temp_to_out;
        always_comb begin
            ready_early = out_ready || (!temp_valid_reg && (!out_valid_reg || !in_valid));
            to_out      = ready_reg && (out_ready || !out_valid_reg);
            to_temp     = ready_reg && !to_out;
            temp_to_out = !ready_reg && out_ready;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ready_reg      <= 1'b0;
                out_valid_reg  <= 1'b0;
                temp_valid_reg <= 1'b0;
                out_reg        <= '0;
                temp_reg       <= '0;
            end else begin
                ready_reg <= ready_early;
                if (to_out) begin
                    out_valid_reg <= in_valid;
                    out_reg       <= in_data;
                end else if (temp_to_out) begin
                    out_valid_reg <= temp_valid_reg;
                    out_reg       <= temp_reg;
                end
                if (to_temp) begin
                    temp_valid_reg <= in_valid;
                    temp_reg       <= in_data;
                end else if (temp_to_out) begin
                    temp_valid_reg <= 1'b0;
                end
            end
        end
        assign in_ready  = ready_reg;
        assign out_valid = out_valid_reg;
        assign out_data  = out_reg;
    end else if (REG_TYPE == 1) begin : g_simple
        logic             ready_reg, out_valid_reg, valid_next;
        logic [WIDTH-1:0] out_reg;
        // Ready only when the single buffer will be empty, hence a bubble after each beat.
        always_comb valid_next = ready_reg ? in_valid : (out_ready ? 1'b0 : out_valid_reg);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ready_reg     <= 1'b0;
                out_valid_reg <= 1'b0;
                out_reg       <= '0;
            end else begin
                ready_reg     <= !valid_next;
                out_valid_reg <= valid_next;
                if (ready_reg) out_reg <= in_data;
            end
        end
        assign in_ready  = ready_reg;
        assign out_valid = out_valid_reg;
        assign out_data  = out_reg;
    end else begin : g_bypass
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end
endmodule

module axil_register_wr #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int AW_REG_TYPE = 1,
    parameter int W_REG_TYPE  = 1,
    parameter int B_REG_TYPE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);
    logic [ADDR_WIDTH+2:0]          aw_out;
    logic [DATA_WIDTH+STRB_WIDTH-1:0] w_out;

    axil_register_wr_slice #(.WIDTH(ADDR_WIDTH + 3), .REG_TYPE(AW_REG_TYPE)) u_aw (
        .clk(clk), .rst(rst),
        .in_data({s_axil_awprot, s_axil_awaddr}), .in_valid(s_axil_awvalid), .in_ready(s_axil_awready),
        .out_data(aw_out), .out_valid(m_axil_awvalid), .out_ready(m_axil_awready)
    );
    assign {m_axil_awprot, m_axil_awaddr} = aw_out;

    axil_register_wr_slice #(.WIDTH(DATA_WIDTH + STRB_WIDTH), .REG_TYPE(W_REG_TYPE)) u_w (
        .clk(clk), .rst(rst),
        .in_data({s_axil_wstrb, s_axil_wdata}), .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
        .out_data(w_out), .out_valid(m_axil_wvalid), .out_ready(m_axil_wready)
    );
    assign {m_axil_wstrb, m_axil_wdata} = w_out;

    axil_register_wr_slice #(.WIDTH(2), .REG_TYPE(B_REG_TYPE)) u_b (
        .clk(clk), .rst(rst),
        .in_data(m_axil_bresp), .in_valid(m_axil_bvalid), .in_ready(m_axil_bready),
        .out_data(s_axil_bresp), .out_valid(s_axil_bvalid), .out_ready(s_axil_bready)
    );
endmodule
